// File: rtl/dlx_fetch.sv
// dlx_fetch - instruction-fetch stage for the multicycle DLX core.
//
// Prefetches the next sequential instruction word into a one-entry buffer
// between IF pulses. The buffer is handed to decode (ir/pc) when the
// controller raises if_en. Branch redirects flush the buffer and steer the
// prefetch address. A response already in flight at the time of a redirect
// is discarded when it arrives.
//
// Parameters:
//   AW        address width (byte addresses, word aligned)
//   DW        instruction width
//   RESET_PC  first fetch address after reset
//   NOP_WORD  filler loaded into ir on a fetch miss and at reset
//
// Ports:
//   clk, reset_n                 core clock, asynchronous active-low reset
//   if_en                        IF stage enable (one-cycle pulse)
//   redirect_valid, redirect_pc  taken branch/jump and its target
//   imem_req, imem_addr          fetch request and address to instruction memory
//   imem_gnt                     request accepted
//   imem_rvalid, imem_rdata      read response (one per grant, in order)
//   ir, pc, npc                  instruction, its address, and address + 4
//   ir_valid                     ir holds a fetched instruction (not NOP filler)
//   fetch_miss                   registered pulse after an if_en that missed
//   miss_cnt                     saturating miss counter
//
// Build option: define DLX_FETCH_MISS_CNT_EN to enable the miss counter.
// Without it, miss_cnt is tied to zero and no counter flops exist.

module dlx_fetch #(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [DW-1:0] NOP_WORD = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_en,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] npc,
    output logic          ir_valid,
    output logic          fetch_miss,
    output logic [15:0]   miss_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FULL
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fpc_q, fpc_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] buf_data_q, buf_data_d;
    logic [AW-1:0] buf_pc_q, buf_pc_d;
    logic [DW-1:0] ir_q;
    logic [AW-1:0] pc_q;
    logic          ir_valid_q;
    logic          fetch_miss_q;

    logic [AW-1:0] redirect_tgt;
    logic          hit;
    logic          unused_redirect_lsbs;

    // Targets are forced onto a word boundary.
    assign redirect_tgt         = {redirect_pc[AW-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A redirect in the same cycle turns an otherwise-hitting if_en into a miss.
    assign hit = if_en && (state_q == S_FULL) && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        drop_d     = drop_q;
        buf_data_d = buf_data_q;
        buf_pc_d   = buf_pc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) fpc_d = redirect_tgt;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    fpc_d = redirect_tgt;
                    // Granted request already carries the old address.
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fpc_d = redirect_tgt;
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        buf_data_d = imem_rdata;
                        buf_pc_d   = fpc_q;
                        fpc_d      = fpc_q + AW'(4);
                        state_d    = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    fpc_d   = redirect_tgt;
                    state_d = S_REQ;
                end else if (if_en) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            fpc_q        <= RESET_PC;
            drop_q       <= 1'b0;
            ir_q         <= NOP_WORD;
            pc_q         <= RESET_PC;
            ir_valid_q   <= 1'b0;
            fetch_miss_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            drop_q       <= drop_d;
            fetch_miss_q <= if_en && !hit;
            if (hit) begin
                ir_q       <= buf_data_q;
                pc_q       <= buf_pc_q;
                ir_valid_q <= 1'b1;
            end else if (if_en) begin
                ir_q       <= NOP_WORD;
                ir_valid_q <= 1'b0;
            end
        end
    end

    // Buffer contents are only meaningful in FULL, so they need no reset.
    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
        buf_pc_q   <= buf_pc_d;
    end

`ifdef DLX_FETCH_MISS_CNT_EN
    logic [15:0] miss_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_cnt_q <= '0;
        end else if (fetch_miss_q && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign miss_cnt = miss_cnt_q;
`else
    assign miss_cnt = '0;
`endif

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = fpc_q;
    assign ir         = ir_q;
    assign pc         = pc_q;
    assign npc        = pc_q + AW'(4);
    assign ir_valid   = ir_valid_q;
    assign fetch_miss = fetch_miss_q;

endmodule

// File: tb/tb_dlx_fetch.sv
// Randomized bench for dlx_fetch. A transaction-level reference model tracks
// the prefetch pointer, the single buffered word and any outstanding memory
// transaction, and predicts ir/pc/ir_valid/fetch_miss/miss_cnt and the
// request stream. The bench itself plays instruction memory; memory content
// is a fixed function of the address.

module tb_dlx_fetch;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP_WORD = 32'h0;

    logic          clk;
    logic          reset_n;
    logic          if_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic          ir_valid;
    logic          fetch_miss;
    logic [15:0]   miss_cnt;

    dlx_fetch #(
        .AW(AW), .DW(DW), .RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .if_en(if_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .pc(pc), .npc(npc), .ir_valid(ir_valid),
        .fetch_miss(fetch_miss), .miss_cnt(miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1111_0000 + a;
    endfunction

    // Reference model state
    bit          m_idle, m_out, m_stale, m_bvalid;
    logic [31:0] m_fpc, m_bpc;
    logic [31:0] e_ir, e_pc;
    bit          e_v, e_miss;
    logic [15:0] e_cnt;

    // Memory model state
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr, mem_pend;

    // Stimulus knobs
    int          lat_min, lat_max, gnt_pct, rand_rd_pct;
    int          ifen_ctr;
    int          rd_mode;   // 0 none, 1 when waiting, 2 with if_en on full buffer, 3 now
    logic [31:0] rd_pc;

    task automatic model_reset();
        m_idle = 1; m_out = 0; m_stale = 0; m_bvalid = 0;
        m_fpc = RESET_PC; m_bpc = RESET_PC;
        e_ir = NOP_WORD; e_pc = RESET_PC; e_v = 0; e_miss = 0; e_cnt = 16'd0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0; mem_pend = 0;
        ifen_ctr = 1; rd_mode = 0;
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".ir"}, ir, e_ir);
        chk({ph, ".pc"}, pc, e_pc);
        chk({ph, ".npc"}, npc, e_pc + 32'd4);
        chk({ph, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, e_v});
        chk({ph, ".fetch_miss"}, {31'd0, fetch_miss}, {31'd0, e_miss});
`ifdef DLX_FETCH_MISS_CNT_EN
        chk({ph, ".miss_cnt"}, {16'd0, miss_cnt}, {16'd0, e_cnt});
`else
        chk({ph, ".miss_cnt"}, {16'd0, miss_cnt}, 32'd0);
`endif
    endtask

    // One clock: called at a falling edge, returns at the next falling edge.
    task automatic cycle(input string ph);
        bit          exp_req, hit, rd;
        logic [31:0] tgt;
        // drive memory response
        if (mem_busy) begin
            mem_cnt--;
            imem_rvalid = (mem_cnt == 0);
        end else begin
            imem_rvalid = 1'b0;
        end
        imem_rdata = imem_rvalid ? memf(mem_addr) : $urandom;
        exp_req = !m_idle && !m_out && !m_bvalid;
        chk({ph, ".imem_req"}, {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk({ph, ".imem_addr"}, imem_addr, m_fpc);
        imem_gnt = imem_req && !mem_busy && ($urandom_range(99) < gnt_pct);
        mem_pend = imem_addr;
        if_en    = (ifen_ctr == 0);
        ifen_ctr = (ifen_ctr == 4) ? 0 : ifen_ctr + 1;
        redirect_valid = 1'b0;
        redirect_pc    = $urandom;
        if ((rd_mode == 1 && m_out) || (rd_mode == 2 && if_en && m_bvalid) || rd_mode == 3) begin
            redirect_valid = 1'b1;
            redirect_pc    = rd_pc;
            rd_mode        = 0;
        end else if (rand_rd_pct > 0 && $urandom_range(99) < rand_rd_pct) begin
            redirect_valid = 1'b1;
        end
        @(posedge clk);
        rd  = redirect_valid;
        tgt = redirect_pc & 32'hFFFF_FFFC;
`ifdef DLX_FETCH_MISS_CNT_EN
        if (e_miss && e_cnt != 16'hFFFF) e_cnt++;
`endif
        hit = if_en && m_bvalid && !rd;
        if (hit) begin
            e_ir = memf(m_bpc); e_pc = m_bpc; e_v = 1;
            m_bvalid = 0;
        end else if (if_en) begin
            e_ir = NOP_WORD; e_v = 0;
        end
        e_miss = if_en && !hit;
        if (rd) begin
            m_bvalid = 0;
            m_fpc    = tgt;
            if (m_out) begin
                if (imem_rvalid) m_out = 0;
                else m_stale = 1;
            end
            if (imem_gnt) begin m_out = 1; m_stale = 1; end
        end else if (imem_gnt) begin
            m_out = 1; m_stale = 0;
        end else if (imem_rvalid && m_out) begin
            m_out = 0;
            if (!m_stale) begin
                m_bvalid = 1; m_bpc = m_fpc; m_fpc = m_fpc + 32'd4;
            end
            m_stale = 0;
        end
        m_idle = 0;
        // memory bookkeeping
        if (imem_rvalid) mem_busy = 0;
        if (imem_gnt) begin
            mem_busy = 1; mem_addr = mem_pend;
            mem_cnt  = $urandom_range(lat_max, lat_min);
        end
        #1;
        check_outputs(ph);
        @(negedge clk);
    endtask

    // Called at a falling edge; asserts reset, checks reset values, releases.
    task automatic do_reset();
        reset_n = 1'b0;
        if_en = 0; redirect_valid = 0; redirect_pc = 0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        model_reset();
        #1;
        check_outputs("rst");
        chk("rst.imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst.imem_addr", imem_addr, RESET_PC);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run(input string ph, input int n);
        for (int i = 0; i < n; i++) cycle(ph);
    endtask

    initial begin
        rand_rd_pct = 0; lat_min = 1; lat_max = 1; gnt_pct = 100;
        reset_n = 1'b0;
        @(negedge clk);
        do_reset();

        // zero-wait memory: every if_en hits, sequential addresses
        run("seq", 60);

        // slow memory: if_en misses, delayed word delivered later
        lat_min = 6; lat_max = 8;
        run("slow", 60);

        // redirect while waiting for a response
        lat_min = 2; lat_max = 4; gnt_pct = 60;
        rd_mode = 1; rd_pc = 32'h0000_0200;
        run("rd_wait", 40);

        // redirect together with if_en on a full buffer, unaligned target
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        for (int i = 0; i < 10; i++) cycle("rd_full_pre");
        rd_mode = 2; rd_pc = 32'h0000_0203;
        run("rd_full", 40);

        // address wrap at the top of memory
        rd_mode = 3; rd_pc = 32'hFFFF_FFF8;
        run("wrap", 40);

        // random latency, grants and redirects
        lat_min = 1; lat_max = 5; gnt_pct = 70; rand_rd_pct = 5;
        run("rand", 800);
        rand_rd_pct = 0;

`ifdef DLX_FETCH_MISS_CNT_EN
        // counter saturation
        dut.miss_cnt_q = 16'hFFFE;
        e_cnt = 16'hFFFE;
        lat_min = 7; lat_max = 8; gnt_pct = 100;
        run("sat", 40);
`endif

        // reset in the middle of an outstanding transaction
        lat_min = 5; lat_max = 5; gnt_pct = 100;
        begin
            int n = 0;
            while (!mem_busy && n < 50) begin
                cycle("pre_rst");
                n++;
            end
            chk("pre_rst.busy_wait", {31'd0, mem_busy}, 32'd1);
        end
        do_reset();
        lat_min = 1; lat_max = 3;
        run("post_rst", 60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
